// File: rtl/psum_writeback.sv
// psum_writeback: holds the MESH_X x MESH_Y partial-sum tile across input-channel
// passes, feeds it back to the PE array as inter_data, then requantizes it and
// streams one row per beat over valid/ready.
//
// Ports
//   clk, rst_n          clock, async active-low reset
//   start               begin a tile (IDLE only); latches num_pass/shift/relu_en
//   num_pass[7:0]       passes per tile (0 behaves as 1)
//   shift[4:0]          requantization right shift
//   relu_en             clamp negative results to 0
//   pe_valid, pe_data   completed pass from the PE array (ACCUM only)
//   inter_data          current psum tile, same packing as pe_data
//   out_valid/ready     row handshake; out_data row, x=0 in LSBs
//   out_last            row MESH_Y-1 is presented
//   busy                not IDLE
//   done                one-cycle pulse after the last row handshake

// Per-lane requantizer: round-half-up, arithmetic shift, optional ReLU, saturate.
module psum_quant #(
  parameter int OUT_BIT = 32,
  parameter int Q_BIT   = 8
) (
  input  logic [OUT_BIT-1:0] psum,
  input  logic [4:0]         shift,
  input  logic               relu_en,
  output logic [Q_BIT-1:0]   q
);
  localparam logic signed [OUT_BIT:0] QMAX = {{(OUT_BIT-Q_BIT+2){1'b0}}, {(Q_BIT-1){1'b1}}};
  localparam logic signed [OUT_BIT:0] QMIN = {{(OUT_BIT-Q_BIT+2){1'b1}}, {(Q_BIT-1){1'b0}}};

  logic        [OUT_BIT:0] rnd;
  logic signed [OUT_BIT:0] r, s;

  always_comb begin
    rnd = '0;
    if (shift != 5'd0) rnd = {{OUT_BIT{1'b0}}, 1'b1} << (shift - 5'd1);
    // one extra bit of headroom so the rounding add cannot wrap
    r = $signed({psum[OUT_BIT-1], psum}) + $signed(rnd);
    s = r >>> shift;
    if (relu_en && s[OUT_BIT]) s = '0;
    q = s[Q_BIT-1:0];
    if (s > QMAX)      q = QMAX[Q_BIT-1:0];
    else if (s < QMIN) q = QMIN[Q_BIT-1:0];
  end
endmodule

module psum_writeback #(
  parameter int OUT_BIT = 32,
  parameter int MESH_X  = 8,
  parameter int MESH_Y  = 8,
  parameter int Q_BIT   = 8
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic                            start,
  input  logic [7:0]                      num_pass,
  input  logic [4:0]                      shift,
  input  logic                            relu_en,
  input  logic                            pe_valid,
  input  logic [MESH_X*MESH_Y*OUT_BIT-1:0] pe_data,
  output logic [MESH_X*MESH_Y*OUT_BIT-1:0] inter_data,
  output logic                            out_valid,
  input  logic                            out_ready,
  output logic [MESH_X*Q_BIT-1:0]         out_data,
  output logic                            out_last,
  output logic                            busy,
  output logic                            done
);
  localparam int RW = (MESH_Y > 1) ? $clog2(MESH_Y) : 1;
  localparam logic [RW-1:0] LAST_ROW = RW'(MESH_Y - 1);

  typedef enum logic [1:0] {IDLE, ACCUM, DRAIN} state_t;
  state_t state_q, state_d;

  logic [MESH_Y-1:0][MESH_X-1:0][OUT_BIT-1:0] psum_q;
  logic [MESH_X-1:0][Q_BIT-1:0]               row_q;
  logic [7:0]    num_pass_q, pass_cnt;
  logic [4:0]    shift_q;
  logic          relu_q;
  logic [RW-1:0] row_idx, row_sel;
  logic          hs, last_pass, last_row;

  assign inter_data = psum_q;
  assign busy       = (state_q != IDLE);
  assign hs         = out_valid & out_ready;
  assign last_row   = (row_idx == LAST_ROW);
  assign last_pass  = (pass_cnt + 8'd1) == ((num_pass_q == 8'd0) ? 8'd1 : num_pass_q);
  // row to load into the output register: row 0 on DRAIN entry, else the next one
  assign row_sel    = out_valid ? row_idx + 1'b1 : '0;

  for (genvar i = 0; i < MESH_X; i++) begin : g_lane
    psum_quant #(.OUT_BIT(OUT_BIT), .Q_BIT(Q_BIT)) u_quant (
      .psum    (psum_q[row_sel][i]),
      .shift   (shift_q),
      .relu_en (relu_q),
      .q       (row_q[i])
    );
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = ACCUM;
      ACCUM:   if (pe_valid && last_pass) state_d = DRAIN;
      DRAIN:   if (hs && last_row) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      psum_q     <= '0;
      num_pass_q <= '0;
      pass_cnt   <= '0;
      shift_q    <= '0;
      relu_q     <= 1'b0;
      row_idx    <= '0;
      out_valid  <= 1'b0;
      out_data   <= '0;
      out_last   <= 1'b0;
      done       <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state_q)
        IDLE: if (start) begin
          num_pass_q <= num_pass;
          shift_q    <= shift;
          relu_q     <= relu_en;
          psum_q     <= '0;
          pass_cnt   <= '0;
        end
        ACCUM: if (pe_valid) begin
          psum_q   <= pe_data;
          pass_cnt <= pass_cnt + 8'd1;
        end
        DRAIN: begin
          if (hs && last_row) begin
            out_valid <= 1'b0;
            out_last  <= 1'b0;
            row_idx   <= '0;
            done      <= 1'b1;
          end else if (!out_valid || out_ready) begin
            // first cycle of DRAIN loads row 0; each handshake loads the next row
            out_valid <= 1'b1;
            out_data  <= row_q;
            out_last  <= (row_sel == LAST_ROW);
            row_idx   <= row_sel;
          end
        end
        default: ;
      endcase
    end
  end
endmodule

// File: doc/psum_writeback.md
# psum_writeback

Output stage downstream of the PE array. It holds the MESH_X×MESH_Y partial-sum tile across input-channel passes and drives it back to the PE as `inter_data`. After the final pass it requantizes the tile (round, shift, optional ReLU, saturate) and streams it out one row per beat over a valid/ready interface toward the feature-map buffer.

## Interface
- `OUT_BIT`, 32: width of one partial sum, signed two's complement
- `MESH_X`, 8: elements per row
- `MESH_Y`, 8: rows per tile
- `Q_BIT`, 8: width of one output element, signed
- `clk` in 1: single clock; all state changes on its rising edge
- `rst_n` in 1: asynchronous, active-low reset
- `start` in 1: begin a tile; sampled only in IDLE
- `num_pass` in 8: passes per tile, latched on `start`; 0 is treated as 1
- `shift` in 5: right-shift amount, latched on `start`
- `relu_en` in 1: ReLU enable, latched on `start`
- `pe_valid` in 1: `pe_data` holds a completed pass this cycle
- `pe_data` in MESH_X*MESH_Y*OUT_BIT: PE output. Element e=y*MESH_X+x occupies bits [(e+1)*OUT_BIT-1 : e*OUT_BIT]
- `inter_data` out MESH_X*MESH_Y*OUT_BIT: current psum register, same packing as `pe_data`
- `out_valid` out 1: `out_data` holds a valid row
- `out_ready` in 1: consumer accepts the row
- `out_data` out MESH_X*Q_BIT: one row, with x=0 in the LSBs
- `out_last` out 1: current row is y=MESH_Y-1
- `busy` out 1: state is not IDLE
- `done` out 1: one-cycle pulse after the last row is accepted

## Operation
- The block has three states: IDLE, ACCUM and DRAIN.
- **IDLE, start=1**
  - Latch `num_pass`, `shift` and `relu_en`.
  - Clear the psum register to 0 and the pass counter to 0.
  - Go to ACCUM.
- **ACCUM, pe_valid=1**
  - psum register ← `pe_data`. The PE has already added `inter_data`.
  - Increment the pass counter.
  - On reaching `num_pass` (or 1 if `num_pass`=0), go to DRAIN and load row 0 into the output register.
- **DRAIN**
  - `out_valid`=1.
  - On `out_valid && out_ready`, load the next row.
  - After the handshake on row MESH_Y-1, drop `out_valid`, pulse `done` and go to IDLE.
- **Element quantization**, for s=`shift` and psum p:
  - r = p + (s>0 ? 2^(s-1) : 0), computed at OUT_BIT+1 bits so it cannot overflow.
  - q = r >>> s (arithmetic).
  - If `relu_en` and q<0, q=0.
  - Saturate to [-2^(Q_BIT-1), 2^(Q_BIT-1)-1].
- **Ignored inputs**
  - `start` outside IDLE is ignored.
  - `pe_valid` outside ACCUM is ignored; the psum register is unchanged.
- **Update rule for `inter_data`:** it changes only on a `start` clear or a `pe_valid` capture. The controller spaces passes by at least the PE adder-tree latency.
- **Reset:** asynchronous `rst_n`=0 at any time, including mid-ACCUM or mid-DRAIN, forces IDLE. The partial tile is discarded.

## Timing
- **Reset values:**
  - `inter_data`=0, `out_data`=0.
  - `out_valid`=0, `out_last`=0.
  - `busy`=0, `done`=0.
  - Pass counter 0, row index 0.
- **`start` sampled at edge S:**
  - `busy`=1 and `inter_data`=0 from S.
  - `pe_valid` is accepted from the edge after S onward.
- **`pe_valid` sampled at edge C:** the captured value appears on `inter_data` after C. Latency is 1 cycle.
- **Final capture at C:** DRAIN is entered at C. Row 0 is registered at C+1, so `out_valid` is first high after C+1.
- **Row throughput:** 1 row/cycle while `out_ready`=1.
- **Stall:** while `out_valid` && !`out_ready`, `out_data` and `out_last` are held stable.
- **`out_valid` stability:** it never drops without a handshake, except on reset.
- **`out_last`:** high exactly while row MESH_Y-1 is presented.
- **Completion:** for a last-row handshake at edge L, `done`=1 for the cycle after L. In that same cycle `busy`=0 and `out_valid`=0.
- **Restart:** a new `start` is accepted from the edge after L onward.

## Test plan
- **Single pass:** `num_pass`=1, `shift`=0, `relu_en`=0, element e=e-32, `out_ready`=1.
  - Expect 8 consecutive rows, row y element x = y*8+x-32.
  - `out_last` on row 7 only, then `done` pulses once.
- **Rounding/saturation:** `shift`=4, `relu_en`=0, elements 2047, -24, -2049, 40.
  - Expect outputs 127, -1, -128, 3.
- **ReLU:** `relu_en`=1, `shift`=0, elements -5, 0, 200, 7.
  - Expect outputs 0, 0, 127, 7.
- **Multi-pass:** `num_pass`=3, three `pe_valid` with element values 10, 25, 60.
  - Expect `inter_data`=0 after `start`, then 10, then 25.
  - No `out_valid` until after the third capture; output is 60.
  - A 4th `pe_valid` during DRAIN is ignored.
- **Backpressure:** toggle `out_ready` at a 1-in-3 duty.
  - Expect `out_data` and `out_last` stable while stalled.
  - Expect exactly 8 handshakes, in order; `start` pulsed mid-DRAIN has no effect.
- **Reset:** assert `rst_n`=0 during row 3 of DRAIN.
  - Expect all outputs at reset values immediately.
  - A new tile afterwards drains correctly from row 0.
